// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Purpose:
//   Shares one single-ported, variable-latency backing memory between the
//   CPU instruction-fetch (IF) port and the data-memory (DM) port. When both
//   ports request at once, the port that did not win last time goes first.
//   Each requester uses a level req / one-cycle ack handshake. The memory
//   side uses a req / ready handshake. All outputs come straight from
//   registers.
//
// Parameters:
//   ADDR_W  address width, all ports
//   DATA_W  data width, all ports
//   CNT_W   width of the saturating conflict counter
//
// Ports:
//   clk_i          clock, all logic on the rising edge
//   rst_i          synchronous, active-low reset
//   if_req_i       instruction read request (level)
//   if_addr_i      instruction address
//   if_ack_o       one-cycle completion pulse to IF
//   if_rdata_o     instruction word, valid with if_ack_o, held afterwards
//   dm_req_i       data request (level)
//   dm_we_i        1 = write, 0 = read
//   dm_addr_i      data address
//   dm_wdata_i     write data
//   dm_ack_o       one-cycle completion pulse to DM
//   dm_rdata_o     read data, valid with dm_ack_o, held afterwards
//   mem_req_o      request to memory, held until mem_ready_i
//   mem_we_o       write enable to memory
//   mem_addr_o     latched winner address
//   mem_wdata_o    latched write data (0 for IF)
//   mem_rdata_i    memory read data, sampled while mem_ready_i is high
//   mem_ready_i    memory completion
//   conflict_cnt_o number of IDLE cycles in which both ports requested
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_ack_o,
  output logic [DATA_W-1:0] if_rdata_o,
  input  logic              dm_req_i,
  input  logic              dm_we_i,
  input  logic [ADDR_W-1:0] dm_addr_i,
  input  logic [DATA_W-1:0] dm_wdata_i,
  output logic              dm_ack_o,
  output logic [DATA_W-1:0] dm_rdata_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              mem_ready_i,
  output logic [CNT_W-1:0]  conflict_cnt_o
);

  // One state per phase of a transaction, split by which port owns it, so
  // the completion path knows which ack and which rdata register to use
  // without keeping a separate owner flag.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_BUSY_I,
    ST_BUSY_D,
    ST_ACK_I,
    ST_ACK_D
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t            state_q, state_d;

  // 0 = IF was granted last, 1 = DM was granted last. Reset value 0 makes the
  // first simultaneous request after reset go to DM.
  logic              last_dm_q, last_dm_d;

  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              if_ack_q, if_ack_d;
  logic              dm_ack_q, dm_ack_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
  logic [CNT_W-1:0]  conflict_q, conflict_d;

  logic              both_req;
  logic              grant_dm;

  // Round-robin choice. DM wins when it is the only requester. When both
  // request, DM wins only if IF was the last winner. This is only acted on
  // in IDLE.
  always_comb begin
    both_req = if_req_i & dm_req_i;
    grant_dm = dm_req_i & (~if_req_i | ~last_dm_q);
  end

  // Next-state and next-output logic. Every register holds its value by
  // default. The ack pulses default to 0 so they last exactly one cycle.
  // The payload registers are written only when a new transaction is
  // granted, so they stay stable for the whole BUSY phase however long the
  // memory takes.
  always_comb begin
    state_d     = state_q;
    last_dm_d   = last_dm_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_ack_d    = 1'b0;
    dm_ack_d    = 1'b0;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    conflict_d  = conflict_q;

    case (state_q)
      ST_IDLE: begin
        if (both_req && (conflict_q != CNT_MAX)) begin
          conflict_d = conflict_q + CNT_ONE;
        end
        if (if_req_i || dm_req_i) begin
          mem_req_d = 1'b1;
          if (grant_dm) begin
            state_d     = ST_BUSY_D;
            last_dm_d   = 1'b1;
            mem_we_d    = dm_we_i;
            mem_addr_d  = dm_addr_i;
            mem_wdata_d = dm_wdata_i;
          end else begin
            state_d     = ST_BUSY_I;
            last_dm_d   = 1'b0;
            mem_we_d    = 1'b0;
            mem_addr_d  = if_addr_i;
            mem_wdata_d = '0;
          end
        end
      end

      ST_BUSY_I: begin
        if (mem_ready_i) begin
          state_d    = ST_ACK_I;
          mem_req_d  = 1'b0;
          if_ack_d   = 1'b1;
          if_rdata_d = mem_rdata_i;
        end
      end

      // A DM write completes without touching dm_rdata. The read data
      // register keeps the result of the last DM read.
      ST_BUSY_D: begin
        if (mem_ready_i) begin
          state_d   = ST_ACK_D;
          mem_req_d = 1'b0;
          dm_ack_d  = 1'b1;
          if (!mem_we_q) begin
            dm_rdata_d = mem_rdata_i;
          end
        end
      end

      // The ack is on the outputs during this cycle. No arbitration happens
      // here, so a request still held after the ack is treated as a new
      // request in the next IDLE.
      ST_ACK_I,
      ST_ACK_D: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d   = ST_IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  // State and output registers. Reset is synchronous and overrides
  // everything else, including a transaction still waiting on the memory.
  // That transaction is dropped and never acknowledged.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q     <= ST_IDLE;
      last_dm_q   <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_ack_q    <= 1'b0;
      dm_ack_q    <= 1'b0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      conflict_q  <= '0;
    end else begin
      state_q     <= state_d;
      last_dm_q   <= last_dm_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_ack_q    <= if_ack_d;
      dm_ack_q    <= dm_ack_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      conflict_q  <= conflict_d;
    end
  end

  assign if_ack_o       = if_ack_q;
  assign if_rdata_o     = if_rdata_q;
  assign dm_ack_o       = dm_ack_q;
  assign dm_rdata_o     = dm_rdata_q;
  assign mem_req_o      = mem_req_q;
  assign mem_we_o       = mem_we_q;
  assign mem_addr_o     = mem_addr_q;
  assign mem_wdata_o    = mem_wdata_q;
  assign conflict_cnt_o = conflict_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Purpose:
//   Directed bench for mem_port_arbiter.
//   - A small memory model answers mem_req_o after a programmable number of
//     wait cycles. Its read data comes from a fixed address-to-word table.
//   - The stimulus pushes the expected memory-side payloads and the expected
//     acks into two queues.
//   - Two monitors pop these queues whenever the DUT raises mem_req_o or an
//     ack, and compare what they see.
//
// Ports:
//   none (top-level bench)
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 4;

  logic              clk_i;
  logic              rst_i;
  logic              if_req_i;
  logic [ADDR_W-1:0] if_addr_i;
  logic              if_ack_o;
  logic [DATA_W-1:0] if_rdata_o;
  logic              dm_req_i;
  logic              dm_we_i;
  logic [ADDR_W-1:0] dm_addr_i;
  logic [DATA_W-1:0] dm_wdata_i;
  logic              dm_ack_o;
  logic [DATA_W-1:0] dm_rdata_o;
  logic              mem_req_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic [DATA_W-1:0] mem_rdata_i;
  logic              mem_ready_i;
  logic [CNT_W-1:0]  conflict_cnt_o;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
  } mem_exp_t;

  typedef struct {
    bit          is_dm;
    logic [31:0] rdata;
    int          cnt;
  } ack_exp_t;

  mem_exp_t memq[$];
  ack_exp_t ackq[$];

  int errors = 0;
  int checks = 0;
  int ready_delay = 0;
  int wait_cnt = 0;

  mem_port_arbiter #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .if_req_i      (if_req_i),
    .if_addr_i     (if_addr_i),
    .if_ack_o      (if_ack_o),
    .if_rdata_o    (if_rdata_o),
    .dm_req_i      (dm_req_i),
    .dm_we_i       (dm_we_i),
    .dm_addr_i     (dm_addr_i),
    .dm_wdata_i    (dm_wdata_i),
    .dm_ack_o      (dm_ack_o),
    .dm_rdata_o    (dm_rdata_o),
    .mem_req_o     (mem_req_o),
    .mem_we_o      (mem_we_o),
    .mem_addr_o    (mem_addr_o),
    .mem_wdata_o   (mem_wdata_o),
    .mem_rdata_i   (mem_rdata_i),
    .mem_ready_i   (mem_ready_i),
    .conflict_cnt_o(conflict_cnt_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  // Backing-memory contents seen by reads. Writes are not stored.
  function automatic logic [31:0] memData(input logic [31:0] a);
    case (a)
      32'h0000_0004: memData = 32'h2001_000A;
      32'h0000_0008: memData = 32'h1234_5678;
      32'h0000_0040: memData = 32'h1111_0040;
      32'h0000_0044: memData = 32'h3333_0044;
      32'h0000_0080: memData = 32'h2222_0080;
      32'h0000_0100: memData = 32'h4444_0100;
      32'h0000_0200: memData = 32'h5555_0200;
      default:       memData = 32'hBAD0_0000 | a;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [95:0] actual,
                             input logic [95:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input bit ireq, input logic [31:0] iaddr,
                               input bit dreq, input bit dwe,
                               input logic [31:0] daddr, input logic [31:0] dwdata);
    if_req_i   = ireq;
    if_addr_i  = iaddr;
    dm_req_i   = dreq;
    dm_we_i    = dwe;
    dm_addr_i  = daddr;
    dm_wdata_i = dwdata;
  endtask

  task automatic pushMem(input logic [31:0] a, input logic we, input logic [31:0] wd);
    mem_exp_t e;
    e.addr = a;
    e.we = we;
    e.wdata = wd;
    memq.push_back(e);
  endtask

  task automatic pushAck(input bit is_dm, input logic [31:0] rd, input int cnt);
    ack_exp_t e;
    e.is_dm = is_dm;
    e.rdata = rd;
    e.cnt = cnt;
    ackq.push_back(e);
  endtask

  // Wait, within a cycle budget, for the ack of one port. Returns at the
  // falling edge where that ack is seen.
  task automatic waitAck(input bit is_dm, input int budget);
    bit got;
    got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge clk_i);
      if ((is_dm && dm_ack_o === 1'b1) || (!is_dm && if_ack_o === 1'b1)) got = 1'b1;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("[TB] FAIL ack_timeout: no %s ack within %0d cycles", is_dm ? "DM" : "IF", budget);
    end
  endtask

  // Memory model: drives ready for one cycle after ready_delay wait cycles
  // of a held request.
  always @(negedge clk_i) begin
    if (mem_req_o === 1'b1) begin
      if (wait_cnt == ready_delay) begin
        mem_ready_i = 1'b1;
        mem_rdata_i = memData(mem_addr_o);
        wait_cnt = 0;
      end else begin
        mem_ready_i = 1'b0;
        wait_cnt++;
      end
    end else begin
      mem_ready_i = 1'b0;
      mem_rdata_i = 32'hFFFF_FFFF;
      wait_cnt = 0;
    end
  end

  // Memory-side monitor: checks the payload against the queue when a
  // request starts, then checks it stays stable while the request is held.
  logic        req_prev = 1'b0;
  logic [64:0] cur_payload = '0;
  always @(negedge clk_i) begin
    if (mem_req_o === 1'b1) begin
      if (!req_prev) begin
        if (memq.size() == 0) begin
          checkOutput("unexpected_mem_req", 1, 0);
        end else begin
          mem_exp_t e;
          e = memq.pop_front();
          checkOutput("mem_addr", mem_addr_o, e.addr);
          checkOutput("mem_we", mem_we_o, e.we);
          checkOutput("mem_wdata", mem_wdata_o, e.wdata);
        end
        cur_payload = {mem_we_o, mem_addr_o, mem_wdata_o};
      end else begin
        checkOutput("mem_payload_stable", {mem_we_o, mem_addr_o, mem_wdata_o}, cur_payload);
      end
    end
    req_prev = (mem_req_o === 1'b1);
  end

  // Ack monitor: checks ack order, one-cycle pulses, no overlap, read data
  // and (where given) the conflict count.
  logic ack_prev = 1'b0;
  always @(negedge clk_i) begin
    if (if_ack_o === 1'b1 || dm_ack_o === 1'b1) begin
      checkOutput("ack_overlap", {if_ack_o, dm_ack_o} == 2'b11, 0);
      checkOutput("ack_pulse_len", ack_prev, 0);
      if (ackq.size() == 0) begin
        checkOutput("unexpected_ack", 1, 0);
      end else begin
        ack_exp_t e;
        e = ackq.pop_front();
        checkOutput("ack_port_is_dm", dm_ack_o, e.is_dm);
        if (e.is_dm) checkOutput("dm_rdata", dm_rdata_o, e.rdata);
        else checkOutput("if_rdata", if_rdata_o, e.rdata);
        if (e.cnt >= 0) checkOutput("conflict_cnt_at_ack", conflict_cnt_o, e.cnt);
      end
    end
    ack_prev = (if_ack_o === 1'b1 || dm_ack_o === 1'b1);
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    mem_ready_i = 1'b0;
    mem_rdata_i = '0;
    rst_i = 1'b0;
    applyStimulus(1, 32'h4, 1, 0, 32'h80, 32'h0);

    // Reset held 2 cycles with both requests high.
    repeat (2) begin
      @(negedge clk_i);
      checkOutput("rst_mem_req", mem_req_o, 0);
      checkOutput("rst_mem_we", mem_we_o, 0);
      checkOutput("rst_mem_addr", mem_addr_o, 0);
      checkOutput("rst_mem_wdata", mem_wdata_o, 0);
      checkOutput("rst_acks", {if_ack_o, dm_ack_o}, 0);
      checkOutput("rst_rdata", {if_rdata_o, dm_rdata_o}, 0);
      checkOutput("rst_conflict", conflict_cnt_o, 0);
    end
    applyStimulus(0, 0, 0, 0, 0, 0);
    rst_i = 1'b1;
    @(negedge clk_i);

    // IF only, ready one cycle after mem_req, minimum latency.
    ready_delay = 0;
    pushMem(32'h4, 1'b0, 32'h0);
    pushAck(1'b0, 32'h2001_000A, 0);
    applyStimulus(1, 32'h4, 0, 0, 0, 0);
    @(negedge clk_i);
    checkOutput("if_lat_mem_req", mem_req_o, 1);
    checkOutput("if_lat_no_ack_yet", if_ack_o, 0);
    @(negedge clk_i);
    checkOutput("if_lat_ack", if_ack_o, 1);
    applyStimulus(0, 0, 0, 0, 0, 0);
    @(negedge clk_i);
    checkOutput("if_ack_dropped", if_ack_o, 0);
    checkOutput("if_rdata_held", if_rdata_o, 32'h2001_000A);

    // Round robin after a fresh reset: grants D, I, D, I.
    rst_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b1;
    pushMem(32'h80, 1'b0, 32'h0);
    pushMem(32'h40, 1'b0, 32'h0);
    pushMem(32'h84, 1'b1, 32'hCAFE_F00D);
    pushMem(32'h44, 1'b0, 32'h0);
    pushAck(1'b1, 32'h2222_0080, 1);
    pushAck(1'b0, 32'h1111_0040, 2);
    pushAck(1'b1, 32'h2222_0080, 2);
    pushAck(1'b0, 32'h3333_0044, 2);
    applyStimulus(1, 32'h40, 1, 0, 32'h80, 32'h0);
    waitAck(1'b1, 20);
    applyStimulus(1, 32'h40, 1, 1, 32'h84, 32'hCAFE_F00D);
    waitAck(1'b0, 20);
    applyStimulus(0, 0, 1, 1, 32'h84, 32'hCAFE_F00D);
    waitAck(1'b1, 20);
    applyStimulus(1, 32'h44, 0, 0, 0, 0);
    waitAck(1'b0, 20);
    applyStimulus(0, 0, 0, 0, 0, 0);
    @(negedge clk_i);
    checkOutput("rr_conflict_cnt", conflict_cnt_o, 2);

    // DM write with ready delayed 5 cycles: request held 6 cycles.
    begin
      int n;
      bit got;
      n = 0;
      got = 1'b0;
      ready_delay = 5;
      pushMem(32'h10, 1'b1, 32'hDEAD_BEEF);
      pushAck(1'b1, 32'h2222_0080, 2);
      applyStimulus(0, 0, 1, 1, 32'h10, 32'hDEAD_BEEF);
      for (int i = 0; i < 30 && !got; i++) begin
        @(negedge clk_i);
        if (mem_req_o === 1'b1) n++;
        if (dm_ack_o === 1'b1) got = 1'b1;
      end
      checkOutput("dm_wr_ack_seen", got, 1);
      checkOutput("dm_wr_req_cycles", n, 6);
      applyStimulus(0, 0, 0, 0, 0, 0);
      @(negedge clk_i);
    end

    // Reset while in BUSY_D: the transaction is dropped without an ack.
    ready_delay = 10;
    pushMem(32'h20, 1'b0, 32'h0);
    applyStimulus(0, 0, 1, 0, 32'h20, 32'h0);
    repeat (3) @(negedge clk_i);
    checkOutput("busy_d_mem_req", mem_req_o, 1);
    rst_i = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0);
    @(negedge clk_i);
    rst_i = 1'b1;
    checkOutput("rst_busy_mem_req", mem_req_o, 0);
    checkOutput("rst_busy_dm_ack", dm_ack_o, 0);
    checkOutput("rst_busy_dm_rdata", dm_rdata_o, 0);
    checkOutput("rst_busy_conflict", conflict_cnt_o, 0);
    repeat (12) @(negedge clk_i);
    ready_delay = 1;
    pushMem(32'h8, 1'b0, 32'h0);
    pushAck(1'b0, 32'h1234_5678, 0);
    applyStimulus(1, 32'h8, 0, 0, 0, 0);
    waitAck(1'b0, 20);
    applyStimulus(0, 0, 0, 0, 0, 0);
    @(negedge clk_i);

    // Both requests held for 20 transactions: the 4-bit counter saturates.
    rst_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b1;
    ready_delay = 0;
    for (int k = 1; k <= 20; k++) begin
      if (k % 2 == 1) begin
        pushMem(32'h200, 1'b0, 32'h0);
        pushAck(1'b1, 32'h5555_0200, (k < 15) ? k : 15);
      end else begin
        pushMem(32'h100, 1'b0, 32'h0);
        pushAck(1'b0, 32'h4444_0100, (k < 15) ? k : 15);
      end
    end
    applyStimulus(1, 32'h100, 1, 0, 32'h200, 32'h0);
    for (int k = 1; k <= 20; k++) begin
      waitAck((k % 2) == 1, 20);
    end
    applyStimulus(0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk_i);
    checkOutput("sat_conflict_hold", conflict_cnt_o, 4'hF);

    checkOutput("memq_drained", memq.size(), 0);
    checkOutput("ackq_drained", ackq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
